dds_sweep_ctrl: RTL

Key-driven and autonomous controller for the DDS tuning words. It sits between the key scanner, which supplies `key_value`, and the DDS phase accumulator and LUT, which consume `fre_data` and `pha_data`. It applies manual frequency and phase steps with range clamping, runs a triangle frequency sweep with a programmable dwell, and emits a one-cycle `upd` strobe whenever either word changes.

---
 rtl/dds_sweep_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Key-driven DDS tuning-word controller: clamped manual frequency steps, wrapping
// phase steps, and an autonomous triangle frequency sweep with programmable dwell.
//
// state  | meaning
// S_IDLE | manual control; keys 1/2 adjust frequency, dwell counter parked at 0
// S_UP   | sweeping upward by SWEEP_STEP every DWELL cycles
// S_DOWN | sweeping downward by SWEEP_STEP every DWELL cycles
module dds_sweep_ctrl #(
  parameter logic [15:0] FRE_INIT   = 16'd500,
  parameter logic [15:0] FRE_STEP   = 16'd50,
  parameter logic [15:0] PHA_STEP   = 16'd1000,
  parameter logic [15:0] FRE_MIN    = 16'd100,
  parameter logic [15:0] FRE_MAX    = 16'd10000,
  parameter logic [15:0] SWEEP_STEP = 16'd10,
  parameter logic [23:0] DWELL      = 24'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_value,
  output logic [15:0] fre_data,
  output logic [15:0] pha_data,
  output logic        upd,
  output logic        sweeping,
  output logic        sweep_dir
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

  localparam logic [16:0] LP_MAN_DN_LIM = {1'b0, FRE_MIN} + {1'b0, FRE_STEP};
  localparam logic [16:0] LP_SWP_DN_LIM = {1'b0, FRE_MIN} + {1'b0, SWEEP_STEP};
  localparam logic [23:0] LP_DWELL_TC   = DWELL - 24'd1;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_key_prev;
  logic [23:0] r_dwell, w_dwell_nxt;
  logic [15:0] r_fre, r_pha, w_fre_nxt, w_pha_nxt;
  logic        r_upd, r_sweeping, r_sweep_dir;
  logic        w_press, w_tc;
  logic [16:0] w_man_up, w_swp_up;

  assign w_press  = (key_value != 4'd0) && (key_value != r_key_prev);
  assign w_tc     = (r_dwell == LP_DWELL_TC);
  assign w_man_up = {1'b0, r_fre} + {1'b0, FRE_STEP};
  assign w_swp_up = {1'b0, r_fre} + {1'b0, SWEEP_STEP};

  always_comb begin
    w_state_nxt = r_state;
    w_dwell_nxt = r_dwell;
    w_fre_nxt   = r_fre;
    w_pha_nxt   = r_pha;

    if (r_state != S_IDLE) begin
      if (w_tc) begin
        w_dwell_nxt = '0;
        if (r_state == S_UP) begin
          if (w_swp_up >= {1'b0, FRE_MAX}) begin
            w_fre_nxt   = FRE_MAX;
            w_state_nxt = S_DOWN;
          end else begin
            w_fre_nxt = w_swp_up[15:0];
          end
        end else begin
          if ({1'b0, r_fre} <= LP_SWP_DN_LIM) begin
            w_fre_nxt   = FRE_MIN;
            w_state_nxt = S_UP;
          end else begin
            w_fre_nxt = r_fre - SWEEP_STEP;
          end
        end
      end else begin
        w_dwell_nxt = r_dwell + 24'd1;
      end
    end

    // Key decode runs last so stop/restore override a coincident sweep step.
    if (w_press) begin
      case (key_value)
        4'd1: if (r_state == S_IDLE)
                w_fre_nxt = (w_man_up > {1'b0, FRE_MAX}) ? FRE_MAX : w_man_up[15:0];
        4'd2: if (r_state == S_IDLE)
                w_fre_nxt = ({1'b0, r_fre} < LP_MAN_DN_LIM) ? FRE_MIN : (r_fre - FRE_STEP);
        4'd3: w_pha_nxt = r_pha + PHA_STEP;
        4'd4: w_pha_nxt = r_pha - PHA_STEP;
        4'd5: if (r_state == S_IDLE) begin
                w_state_nxt = S_UP;
                w_dwell_nxt = '0;
              end
        4'd6: if (r_state != S_IDLE) begin
                w_state_nxt = S_IDLE;
                w_dwell_nxt = '0;
                w_fre_nxt   = r_fre;
              end
        4'd7: begin
                w_state_nxt = S_IDLE;
                w_dwell_nxt = '0;
                w_fre_nxt   = FRE_INIT;
                w_pha_nxt   = 16'd0;
              end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_key_prev  <= 4'd0;
      r_dwell     <= '0;
      r_fre       <= FRE_INIT;
      r_pha       <= 16'd0;
      r_upd       <= 1'b0;
      r_sweeping  <= 1'b0;
      r_sweep_dir <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_key_prev  <= key_value;
      r_dwell     <= w_dwell_nxt;
      r_fre       <= w_fre_nxt;
      r_pha       <= w_pha_nxt;
      r_upd       <= (w_fre_nxt != r_fre) || (w_pha_nxt != r_pha);
      r_sweeping  <= (w_state_nxt != S_IDLE);
      r_sweep_dir <= (w_state_nxt == S_UP);
    end
  end

  assign fre_data  = r_fre;
  assign pha_data  = r_pha;
  assign upd       = r_upd;
  assign sweeping  = r_sweeping;
  assign sweep_dir = r_sweep_dir;

endmodule
